// File: rtl/activation_pair_reader_pkg.sv
// Shared widths and FSM encoding for the activation pair reader.
// The default widths must agree with the activation store instance.
package activation_pair_reader_pkg;

    localparam int VALUE_W = 16;
    localparam int ADDR_W  = 10;
    localparam int CNT_W   = 11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_e;

endpackage

// File: rtl/pair_skid_buffer.sv
// Two-entry in-order buffer: an output register plus one skid entry.
// Output data only moves on a pop or when the output slot is empty.
module pair_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic         r_v0;
    logic         r_v1;
    logic [W-1:0] r_d0;
    logic [W-1:0] r_d1;
    logic         w_v0_n;
    logic         w_v1_n;
    logic [W-1:0] w_d0_n;
    logic [W-1:0] w_d1_n;

    always_comb begin
        w_v0_n = r_v0;
        w_v1_n = r_v1;
        w_d0_n = r_d0;
        w_d1_n = r_d1;
        if (i_pop) begin
            if (r_v1) begin
                w_d0_n = r_d1;
                w_v1_n = i_push;
                w_d1_n = i_data;
            end else begin
                w_v0_n = i_push;
                if (i_push) w_d0_n = i_data;
            end
        end else if (i_push) begin
            // The producer's credit check guarantees the skid is free here
            if (!r_v0) begin
                w_v0_n = 1'b1;
                w_d0_n = i_data;
            end else begin
                w_v1_n = 1'b1;
                w_d1_n = i_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_d0 <= '0;
            r_d1 <= '0;
        end else begin
            r_v0 <= w_v0_n;
            r_v1 <= w_v1_n;
            r_d0 <= w_d0_n;
            r_d1 <= w_d1_n;
        end
    end

    assign o_valid = r_v0;
    assign o_data  = r_d0;
    assign o_count = {1'b0, r_v0} + {1'b0, r_v1};

endmodule

// File: rtl/activation_pair_reader.sv
// Streams {A[base_a+i], B[base_b+i]} pairs from the dual-port store,
// hiding its one-cycle read latency behind a credit-gated skid buffer.
module activation_pair_reader
    import activation_pair_reader_pkg::*;
#(
    parameter int VALUE_WIDTH   = VALUE_W,
    parameter int ADDRESS_WIDTH = ADDR_W,
    parameter int COUNT_WIDTH   = CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_a,
    input  logic [ADDRESS_WIDTH-1:0] base_b,
    input  logic [COUNT_WIDTH-1:0]   pair_count,
    input  logic                     store_wr_busy,
    output logic [ADDRESS_WIDTH-1:0] address1,
    output logic [ADDRESS_WIDTH-1:0] address2,
    input  logic [VALUE_WIDTH-1:0]   rd_val1,
    input  logic [VALUE_WIDTH-1:0]   rd_val2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [VALUE_WIDTH-1:0]   out_val1,
    output logic [VALUE_WIDTH-1:0]   out_val2,
    output logic [COUNT_WIDTH-1:0]   out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int DW = 2 * VALUE_WIDTH + COUNT_WIDTH + 1;

    state_e                   r_state;
    state_e                   w_state_n;
    logic                     r_done;
    logic                     w_done_n;
    logic [COUNT_WIDTH-1:0]   r_n;
    logic [COUNT_WIDTH-1:0]   r_k;
    logic [ADDRESS_WIDTH-1:0] r_addr1;
    logic [ADDRESS_WIDTH-1:0] r_addr2;
    logic                     r_inflight;
    logic [COUNT_WIDTH-1:0]   r_inf_idx;
    logic                     r_inf_last;
    logic [1:0]               w_occ;
    logic                     w_pop;
    logic                     w_credit_ok;
    logic                     w_issue;
    logic                     w_k_last;
    logic                     w_launch;
    logic [DW-1:0]            w_push_data;
    logic [DW-1:0]            w_out_data;

    assign w_pop    = out_valid && out_ready;
    assign w_k_last = (r_k == r_n - 1'b1);
    assign w_launch = (r_state == S_IDLE) && start && (pair_count != '0);

    // Buffered plus in-flight pairs, net of this cycle's pop, must stay below 2
    assign w_credit_ok = ({1'b0, w_occ} + {2'b0, r_inflight})
                       < (3'd2 + {2'b0, w_pop});
    assign w_issue = (r_state == S_ISSUE) && !store_wr_busy && w_credit_ok;

    always_comb begin
        w_state_n = r_state;
        w_done_n  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (pair_count != '0) w_state_n = S_ISSUE;
                    else                  w_done_n  = 1'b1;
                end
            end
            S_ISSUE: begin
                if (w_issue && w_k_last) w_state_n = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_pop && out_last) begin
                    w_state_n = S_IDLE;
                    w_done_n  = 1'b1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_done  <= w_done_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_n        <= '0;
            r_k        <= '0;
            r_addr1    <= '0;
            r_addr2    <= '0;
            r_inflight <= 1'b0;
            r_inf_idx  <= '0;
            r_inf_last <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inf_idx  <= r_k;
                r_inf_last <= w_k_last;
                r_k        <= r_k + 1'b1;
                r_addr1    <= r_addr1 + 1'b1;
                r_addr2    <= r_addr2 + 1'b1;
            end
            if (w_launch) begin
                r_n     <= pair_count;
                r_k     <= '0;
                r_addr1 <= base_a;
                r_addr2 <= base_b;
            end
        end
    end

    assign w_push_data = {rd_val1, rd_val2, r_inf_idx, r_inf_last};

    pair_skid_buffer #(
        .W (DW)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_inflight),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_valid (out_valid),
        .o_data  (w_out_data),
        .o_count (w_occ)
    );

    assign {out_val1, out_val2, out_index, out_last} = w_out_data;
    assign address1 = r_addr1;
    assign address2 = r_addr2;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;

endmodule
